uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Frame sequencer between the UART receiver/transmitter and the ALU. It collects a three-byte command frame (operand A, operand B, opcode) from the RX stream and presents it to the ALU with a single-cycle valid strobe. It then latches the ALU result and returns it through a one-byte TX handshake. The block is the only owner of the ALU inputs; the top level instantiates it between `uart_rx`, `alu` and `uart_tx`.

## Interface
Parameters:
- `NB_DATA`, 8, UART byte width and ALU operand/result width.
- `NB_OP`, 6, ALU opcode width; taken from the low `NB_OP` bits of the opcode byte.
- `TIMEOUT_CYC`, 50000, inter-byte timeout in clock cycles. Used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_rx_data` in NB_DATA: received byte. Valid only while `i_rx_done` is 1.
- `i_rx_done` in 1: one-cycle pulse, byte available.
- `o_alu_a`, `o_alu_b` out NB_DATA: registered operands.
- `o_alu_op` out NB_OP: registered opcode.
- `o_alu_valid` out 1: one-cycle execute strobe.
- `i_alu_result` in NB_DATA: combinational ALU result.
- `o_tx_data` out NB_DATA: result byte to the transmitter.
- `o_tx_start` out 1: one-cycle transmit request.
- `i_tx_done` in 1: one-cycle pulse, transmission finished.
- `o_busy` out 1: high in every state except IDLE.
- `o_overrun` out 1: one-cycle pulse when an RX byte is dropped.
- `o_timeout` out 1: one-cycle pulse when a frame is aborted by the timeout.

## Operation
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX. All outputs are registered.
- **IDLE:** on `i_rx_done`, load `o_alu_a` and go to GET_B.
- **GET_B:** on `i_rx_done`, load `o_alu_b` and go to GET_OP.
- **GET_OP:** on `i_rx_done`, load `o_alu_op` from `i_rx_data[NB_OP-1:0]` and go to EXEC. The upper opcode-byte bits are ignored.
- **EXEC:** lasts one cycle. `o_alu_valid` = 1. At the end of the cycle, latch `i_alu_result` into `o_tx_data` and go to SEND.
- **SEND:** lasts one cycle. `o_tx_start` = 1. Go to WAIT_TX.
- **WAIT_TX:** wait for `i_tx_done`, then go to IDLE.
- An `i_tx_done` sampled during SEND is also accepted, and the next state is IDLE.
- An `i_rx_done` in EXEC, SEND or WAIT_TX is dropped, `o_overrun` pulses the next cycle, and the state does not change.
- Operand and opcode registers hold their values until overwritten by the next frame. They are not cleared on return to IDLE.
- Reset values: state = IDLE; `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data` = 0; `o_alu_valid`, `o_tx_start`, `o_busy`, `o_overrun`, `o_timeout` = 0.
- Reset asserted mid-frame forces IDLE immediately and discards the partial frame. No `o_tx_start` is issued after reset is released.
- Undefined state encodings recover to IDLE on the next clock.

## Timing
- Opcode byte `i_rx_done` sampled at edge N:
  - `o_alu_valid` = 1 during cycle N..N+1.
  - `o_tx_data` is valid from edge N+2, and `o_tx_start` = 1 during cycle N+2..N+3.
- `o_tx_data` is stable from `o_tx_start` until the next EXEC.
- Minimum frame-to-frame spacing: the first byte of the next frame is accepted in the cycle after `i_tx_done` is sampled.
- `o_busy` rises one cycle after the first byte is sampled. It falls one cycle after `i_tx_done` is sampled.

## Configuration
- Macro: `UART_ALU_CTRL_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYC+1)` is cleared on every accepted byte and on entry to IDLE.
  - It increments in GET_B and GET_OP.
  - When it reaches `TIMEOUT_CYC - 1` with no `i_rx_done` in that cycle, the FSM goes to IDLE and `o_timeout` pulses for one cycle.
  - If `i_rx_done` arrives in the same cycle as the terminal count, the byte is accepted and no timeout occurs.
- **Undefined:** no counter is built, `o_timeout` is tied to 0, and the FSM waits indefinitely in GET_B and GET_OP.

## Test plan
- Frame 0x05, 0x03, 0x20 (ADD) with the ALU returning 0x08:
  - `o_alu_valid` is a single pulse with `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20.
  - `o_tx_data`=0x08, `o_tx_start` is a single pulse two cycles after the opcode strobe, `o_busy` falls after `i_tx_done`.
- Opcode byte 0xE2 with `NB_OP`=6: `o_alu_op`=0x22.
- `i_rx_done` pulsed during WAIT_TX: `o_overrun` pulses once, the frame completes normally, and the next frame starts clean.
- `i_rst_n` low after byte 2: all outputs are 0 and the state is IDLE. Re-send the full frame 0xFF, 0x01, 0x20 → `o_tx_start` pulses once with `o_tx_data`=0x00.
- With `UART_ALU_CTRL_TIMEOUT_EN` and `TIMEOUT_CYC`=16:
  - Send one byte, then idle for 16 cycles → `o_timeout` pulses and `o_busy`=0.
  - Send byte 2 exactly at the terminal cycle → no timeout.
- `i_tx_done` asserted during SEND: return to IDLE on the next edge, with no hang in WAIT_TX.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame sequencer between uart_rx, the ALU and uart_tx.
// Collects operand A, operand B and an opcode byte, strobes the ALU for one cycle,
// latches the result and hands it to the transmitter with a one-cycle start pulse.
// Optional inter-byte timeout is compiled in with the macro UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_alu_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  if (NB_OP > NB_DATA || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("uart_alu_ctrl: NB_OP must fit in NB_DATA and TIMEOUT_CYC must be at least 2");
  end

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0] state_q, state_d;
  logic       in_frame;    // waiting for byte 2 or byte 3
  logic       rx_dropped;  // byte arrived while the frame is being executed/returned
  logic       timeout_hit;

  assign in_frame   = (state_q == GET_B) || (state_q == GET_OP);
  assign rx_dropped = i_rx_done &&
                      ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX));

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;
  logic            accept;
  logic            timeout_q;

  assign accept      = i_rx_done && ((state_q == IDLE) || in_frame);
  // A byte landing on the terminal count wins over the timeout.
  assign timeout_hit = in_frame && !i_rx_done && (cnt_q == CntLast);
  assign o_timeout   = timeout_q;

  // Inter-byte cycle counter: restarts on every accepted byte and whenever IDLE is entered.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (accept || (state_d == IDLE)) begin
        cnt_q <= '0;
      end else if (in_frame) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_rx_done) state_d = GET_B;
      GET_B: begin
        if (i_rx_done)        state_d = GET_OP;
        else if (timeout_hit) state_d = IDLE;
      end
      GET_OP: begin
        if (i_rx_done)        state_d = EXEC;
        else if (timeout_hit) state_d = IDLE;
      end
      EXEC:    state_d = SEND;
      SEND:    state_d = i_tx_done ? IDLE : WAIT_TX;
      WAIT_TX: if (i_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame/result registers and strobes. Operands persist across frames until overwritten.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_tx_data   <= '0;
      o_alu_valid <= 1'b0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (i_rx_done && (state_q == IDLE))   o_alu_a  <= i_rx_data;
      if (i_rx_done && (state_q == GET_B))  o_alu_b  <= i_rx_data;
      if (i_rx_done && (state_q == GET_OP)) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (state_q == EXEC)                  o_tx_data <= i_alu_result;
      // Valid coincides with EXEC; start and busy trail the state by one cycle.
      o_alu_valid <= (state_d == EXEC);
      o_tx_start  <= (state_q == SEND);
      o_busy      <= (state_q != IDLE);
      o_overrun   <= rx_dropped;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed frames plus randomized frames checked
// against a byte-level reference (frame bytes -> ALU result) and pulse counters.
module tb_uart_alu_ctrl;

  localparam int unsigned NB_DATA     = 8;
  localparam int unsigned NB_OP       = 6;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  logic       alu_valid, tx_start, tx_done, busy, overrun, timeout;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_tx = 0, n_ovr = 0, n_to = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA     (NB_DATA),
    .NB_OP       (NB_OP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_alu_valid  (alu_valid),
    .i_alu_result (alu_result),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_timeout    (timeout)
  );

  // Behavioural ALU used both as environment and as the reference for expected results.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return $signed(a) >>> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // Pulse counters, sampled at the edge that ends each pulse.
  always @(posedge clk) begin
    if (alu_valid) n_valid <= n_valid + 1;
    if (tx_start)  n_tx    <= n_tx + 1;
    if (overrun)   n_ovr   <= n_ovr + 1;
    if (timeout)   n_to    <= n_to + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Entered at the negedge right after the opcode byte was sampled (edge N).
  // mode 0: tx_done in WAIT_TX, 1: tx_done during SEND, 2: RX byte dropped in WAIT_TX.
  task automatic finish_frame(input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] opb, input int mode);
    logic [5:0] eop;
    logic [7:0] eres;
    int nv0, nt0, no0, nto0;
    eop  = opb[5:0];
    eres = alu_fn(ea, eb, eop);
    nv0 = n_valid; nt0 = n_tx; no0 = n_ovr; nto0 = n_to;
    check("alu_valid_on", 32'(alu_valid), 32'd1);
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(eb));
    check("alu_op", 32'(alu_op), 32'(eop));
    check("tx_start_early", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("alu_valid_off", 32'(alu_valid), 32'd0);
    check("tx_data_latched", 32'(tx_data), 32'(eres));
    check("tx_start_n1", 32'(tx_start), 32'd0);
    if (mode == 1) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("tx_start_n2", 32'(tx_start), 32'd1);
    check("tx_data_at_start", 32'(tx_data), 32'(eres));
    check("busy_at_start", 32'(busy), 32'd1);
    if (mode == 1) begin
      @(negedge clk);
      check("busy_fall_send", 32'(busy), 32'd0);
      check("tx_start_off", 32'(tx_start), 32'd0);
    end else begin
      if (mode == 2) begin
        rx_data = 8'hA5;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("overrun_pulse", 32'(overrun), 32'd1);
        check("tx_start_off", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("overrun_single", 32'(overrun), 32'd0);
      end
      repeat ($urandom_range(3)) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      check("busy_fall", 32'(busy), 32'd0);
      check("tx_data_hold", 32'(tx_data), 32'(eres));
    end
    check("valid_count", 32'(n_valid - nv0), 32'd1);
    check("tx_start_count", 32'(n_tx - nt0), 32'd1);
    check("overrun_count", 32'(n_ovr - no0), (mode == 2) ? 32'd1 : 32'd0);
    check("timeout_count", 32'(n_to - nto0), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int gap, input int mode);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(b);
    repeat (gap) @(negedge clk);
    send_byte(opb);
    finish_frame(a, b, opb, mode);
  endtask

  initial begin
    logic [5:0] ops [8];
    int         nto0, nt0;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state.
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_strobes", 32'({alu_valid, tx_start, busy, overrun, timeout}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD frame with busy rise timing.
    send_byte(8'h05);
    check("busy_not_yet", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    send_byte(8'h03);
    send_byte(8'h20);
    finish_frame(8'h05, 8'h03, 8'h20, 0);
    check("add_result", 32'(tx_data), 32'h08);

    // Upper opcode bits ignored: 0xE2 -> 0x22.
    send_frame(8'h10, 8'h07, 8'hE2, 0, 0);
    check("op_masked", 32'(alu_op), 32'h22);

    // Overrun in WAIT_TX, then a clean frame.
    send_frame(8'h0F, 8'hF0, 8'h25, 1, 2);
    send_frame(8'h33, 8'h11, 8'h22, 0, 0);

    // tx_done accepted during SEND.
    send_frame(8'hAA, 8'h55, 8'h26, 2, 1);

    // Reset after byte 2 discards the partial frame.
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_a", 32'(alu_a), 32'd0);
    check("midrst_alu_b", 32'(alu_b), 32'd0);
    check("midrst_outs", 32'({alu_op, tx_data, alu_valid, tx_start, busy, overrun, timeout}),
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nt0 = n_tx;
    repeat (4) @(negedge clk);
    check("midrst_no_start", 32'(n_tx - nt0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    send_frame(8'hFF, 8'h01, 8'h20, 0, 0);
    check("wrap_result", 32'(tx_data), 32'h00);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // One byte then silence: frame aborted after TIMEOUT_CYC cycles.
    send_byte(8'h44);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check("timeout_early", 32'(timeout), 32'd0);
    @(negedge clk);
    check("timeout_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    check("timeout_single", 32'(timeout), 32'd0);
    check("timeout_idle", 32'(busy), 32'd0);
    // Bytes arriving exactly on the terminal count are accepted.
    nto0 = n_to;
    send_byte(8'h12);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    send_byte(8'h34);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    send_byte(8'h20);
    finish_frame(8'h12, 8'h34, 8'h20, 0);
    check("terminal_no_timeout", 32'(n_to - nto0), 32'd0);
`else
    // Without the timeout the FSM waits indefinitely for the next byte.
    nto0 = n_to;
    send_byte(8'h44);
    repeat (40) @(negedge clk);
    check("no_timeout_busy", 32'(busy), 32'd1);
    check("no_timeout_pulse", 32'(n_to - nto0), 32'd0);
    send_byte(8'h02);
    send_byte(8'h24);
    finish_frame(8'h44, 8'h02, 8'h24, 0);
`endif

    // Randomized frames.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb, ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = {2'($urandom), ops[$urandom_range(7)]};
      send_frame(ra, rb, ro, $urandom_range(3), $urandom_range(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
